apb_master_arbiter: RTL

//  Shares one APB4 master port between N_REQ local requesters (CPU-side, DMA, test sequencers).

---
 rtl/apb_master_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Round-robin arbiter that shares one APB4 master port between N_REQ local
//   requesters. Each grant runs one SETUP+ACCESS transfer. The read data,
//   pslverr and a one-cycle completion pulse go back to the winner.
//   Optional feature: define APB_TIMEOUT_EN to end an ACCESS phase with an
//   error after TIMEOUT_CYCLES cycles without pready.
module apb_master_arbiter #(
  parameter int         N_REQ          = 2,
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] PPROT_VAL      = 3'b000,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0]               req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]  req_strb,
  output logic [N_REQ-1:0]               req_done,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  output logic                           req_err,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [2:0]                     pprot,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic                           pready,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]           state;
  logic [IDX_WIDTH-1:0] last;        // most recently served requester
  logic [IDX_WIDTH-1:0] grant;       // owner of the transfer in flight
  logic [IDX_WIDTH-1:0] grant_next;
  logic                 grant_found;
  logic                 access;
  logic                 complete;
  logic                 timeout_hit;

  // Requester index base+off, wrapped into 0..N_REQ-1 without a divider.
  function automatic logic [IDX_WIDTH-1:0] wrap_idx(input logic [IDX_WIDTH-1:0] base,
                                                    input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDX_WIDTH'(sum);
  endfunction

  assign access  = (state == ST_ACCESS);
  assign psel    = (state == ST_SETUP) || access;
  assign penable = access;
  assign pprot   = PPROT_VAL;

  // Round-robin search: first pending requester after the last one served.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    grant_next  = last;
    grant_found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!grant_found && req_valid[wrap_idx(last, off)]) begin
        grant_found = 1'b1;
        grant_next  = wrap_idx(last, off);
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] wait_cnt;

  // Counts ACCESS cycles without pready; cleared on entry to ACCESS.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if (access && !pready) begin
      wait_cnt <= wait_cnt + CNT_WIDTH'(1);
    end
  end

  // Fires in the last allowed ACCESS cycle; a pready in that cycle wins.
  assign timeout_hit = access && !pready &&
                       (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  // Keeps the timeout parameter referenced when the counter is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  assign complete = access && (pready || timeout_hit);

  // Transfer sequencing: capture the winner in IDLE, then SETUP and ACCESS.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (preset) begin
      state  <= ST_IDLE;
      last   <= IDX_WIDTH'(N_REQ - 1);
      grant  <= '0;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            grant  <= grant_next;
            paddr  <= req_addr[int'(grant_next)*ADDR_WIDTH +: ADDR_WIDTH];
            pwrite <= req_write[grant_next];
            // Reads carry no data or strobes on the bus.
            pwdata <= req_write[grant_next] ?
                      req_wdata[int'(grant_next)*DATA_WIDTH +: DATA_WIDTH] : '0;
            pstrb  <= req_write[grant_next] ?
                      req_strb[int'(grant_next)*STRB_WIDTH +: STRB_WIDTH] : '0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (complete) begin
            last  <= grant;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion response to the owner, live only in the finishing ACCESS cycle.
  always_comb begin
    req_done  = '0;
    req_rdata = '0;
    req_err   = 1'b0;
    if (complete) begin
      req_done[grant] = 1'b1;
      req_err         = pready ? pslverr : 1'b1;
      if (pready && !pwrite) req_rdata = prdata;
    end
  end

endmodule
